// File: rtl/logic_unit_sweep.sv
// Bitwise logic unit with an exhaustive operand sweep engine.
// Latency: 1 cycle from accepted operand pair (external or sweep) to out_valid.
// Backpressure: single output register; input and sweep stall while the slot is held.
module logic_unit_sweep #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sweep_start,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [2:0]       out_op,
    output logic             out_zero,
    output logic             busy,
    output logic             done,
    output logic [15:0]      count
);

    localparam int PW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [2:0]       r_op_lat;
    logic [PW-1:0]    r_pair;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_s;
    logic [WIDTH-1:0] r_out_a;
    logic [WIDTH-1:0] r_out_b;
    logic [2:0]       r_out_op;
    logic [15:0]      r_count;

    logic             w_slot_free;
    logic             w_in_ready;
    logic             w_ext_load;
    logic             w_sweep_load;
    logic             w_load;
    logic             w_last_pair;
    logic [WIDTH-1:0] w_pa;
    logic [WIDTH-1:0] w_pb;
    logic [WIDTH-1:0] w_ld_a;
    logic [WIDTH-1:0] w_ld_b;
    logic [2:0]       w_ld_op;
    logic [WIDTH-1:0] w_ld_s;

    function automatic logic [WIDTH-1:0] f_logic(input logic [2:0] sel,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] res;
        case (sel)
            3'd0:    res = ~x & y;
            3'd1:    res = ~x | ~y;
            3'd2:    res = x & y;
            3'd3:    res = x | y;
            3'd4:    res = x ^ y;
            3'd5:    res = ~(x | y);
            3'd6:    res = ~(x ^ y);
            default: res = ~x;
        endcase
        return res;
    endfunction

    // pb is the low half of the pair counter so b advances fastest
    assign w_pa        = r_pair[PW-1:WIDTH];
    assign w_pb        = r_pair[WIDTH-1:0];
    assign w_last_pair = &r_pair;

    // The output slot can take a new result when empty or draining this cycle
    assign w_slot_free  = !r_out_valid || out_ready;
    assign w_in_ready   = (r_state == S_IDLE) && w_slot_free && !sweep_start;
    assign w_ext_load   = in_valid && w_in_ready;
    assign w_sweep_load = (r_state == S_SWEEP) && w_slot_free;
    assign w_load       = w_ext_load || w_sweep_load;

    assign w_ld_a  = (r_state == S_SWEEP) ? w_pa     : a;
    assign w_ld_b  = (r_state == S_SWEEP) ? w_pb     : b;
    assign w_ld_op = (r_state == S_SWEEP) ? r_op_lat : op;
    assign w_ld_s  = f_logic(w_ld_op, w_ld_a, w_ld_b);

    // Output register, handshake counter and sweep control
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op_lat    <= 3'd0;
            r_pair      <= '0;
            r_out_valid <= 1'b0;
            r_out_s     <= '0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_op    <= 3'd0;
            r_count     <= 16'd0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_count <= r_count + 16'd1;
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_s     <= w_ld_s;
                r_out_a     <= w_ld_a;
                r_out_b     <= w_ld_b;
                r_out_op    <= w_ld_op;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (sweep_start) begin
                        r_state  <= S_SWEEP;
                        r_op_lat <= op;
                        r_pair   <= '0;
                    end
                end
                S_SWEEP: begin
                    if (w_sweep_load) begin
                        if (w_last_pair) begin
                            r_state <= S_DONE;
                        end else begin
                            r_pair <= r_pair + {{(PW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_s     = r_out_s;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign out_op    = r_out_op;
    assign out_zero  = (r_out_s == '0);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign count     = r_count;

endmodule
